// File: rtl/sweep_mult_pkg.sv
// Shared types and helpers for the sweep shift-and-add multiplier front end.
package sweep_mult_pkg;

    // Default operand width and the matching product width.
    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_DW_2 = 2 * DEF_DW;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StHold = 2'd3
    } sweep_state_e;

    // Two's-complement magnitude at the default width. The most negative value maps to
    // 2^(DEF_DW-1), which still fits as an unsigned DEF_DW-bit quantity.
    function automatic logic [DEF_DW-1:0] twos_magnitude(input logic [DEF_DW-1:0] x);
        return x[DEF_DW-1] ? ((~x) + DEF_DW'(1)) : x;
    endfunction

endpackage

// File: rtl/sweep_twos_magnitude.sv
// Combinational sign/magnitude split of a two's-complement operand.
module sweep_twos_magnitude
    import sweep_mult_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic [DW-1:0] i_value,
    output logic [DW-1:0] o_mag,
    output logic          o_neg
);

    assign o_neg = i_value[DW-1];

    // At the default width reuse the shared helper; other widths use the same rule inline.
    if (DW == DEF_DW) begin : g_pkg_mag
        assign o_mag = twos_magnitude(i_value);
    end else begin : g_gen_mag
        assign o_mag = i_value[DW-1] ? ((~i_value) + DW'(1)) : i_value;
    end

endmodule

// File: rtl/sweep_mult_controller.sv
// Operand preparation and sequencing for the sweep shift-and-add multiplier.
// A start pulse captures |multiplier| into rgstr1 and |multiplicand| into rgstr2, then rgstr2
// is walked left one bit per RUN cycle while the adder accumulates. The product sign is kept
// for the downstream two's-complement fix-up stage.
module sweep_mult_controller
    import sweep_mult_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned DW_2 = 2 * DW,
    parameter int unsigned CW   = $clog2(DW) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   multiplier,
    input  logic [DW-1:0]   multiplicand,
    input  logic            done_i,
    output logic            l_s,
    output logic            init_FSM,
    output logic            permit,
    output logic [DW-1:0]   rgstr1,
    output logic [DW_2-1:0] rgstr2,
    output logic            sign,
    output logic            busy,
    output logic            result_valid,
    output logic            sync_err
);

    sweep_state_e    r_state;
    sweep_state_e    w_state_next;
    logic [CW-1:0]   r_count;
    logic [DW-1:0]   r_rgstr1;
    logic [DW_2-1:0] r_rgstr2;
    logic            r_sign;
    logic            r_first_hold;
    logic            r_sync_err;

    logic [DW-1:0]   w_mplier_mag;
    logic [DW-1:0]   w_mcand_mag;
    logic            w_mplier_neg;
    logic            w_mcand_neg;
    logic            w_accept;
    logic            w_last_run;

    sweep_twos_magnitude #(
        .DW (DW)
    ) u_mplier_mag (
        .i_value (multiplier),
        .o_mag   (w_mplier_mag),
        .o_neg   (w_mplier_neg)
    );

    sweep_twos_magnitude #(
        .DW (DW)
    ) u_mcand_mag (
        .i_value (multiplicand),
        .o_mag   (w_mcand_mag),
        .o_neg   (w_mcand_neg)
    );

    // Start is honoured only while no sweep is in flight; LOAD and RUN ignore it.
    assign w_accept   = start && ((r_state == StIdle) || (r_state == StHold));
    assign w_last_run = (r_state == StRun) && (r_count == CW'(DW - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: one LOAD cycle, DW RUN cycles, then HOLD until the next start.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StLoad;
            StLoad:  w_state_next = StRun;
            StRun:   if (w_last_run) w_state_next = StHold;
            StHold:  if (w_accept) w_state_next = StLoad;
            default: w_state_next = StIdle;
        endcase
    end

    // Adder control and status strobes, decoded purely from the registered state.
    always_comb begin
        l_s          = 1'b0;
        init_FSM     = 1'b0;
        permit       = 1'b1;
        busy         = 1'b0;
        result_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                init_FSM = 1'b0;
                permit   = 1'b1;
            end
            StLoad: begin
                l_s      = 1'b1;
                init_FSM = 1'b1;
                permit   = 1'b0;
                busy     = 1'b1;
            end
            StRun: begin
                init_FSM = 1'b1;
                permit   = 1'b0;
                busy     = 1'b1;
            end
            StHold: begin
                init_FSM     = 1'b1;
                permit       = 1'b1;
                result_valid = 1'b1;
            end
            default: begin
                permit = 1'b1;
            end
        endcase
    end

    // Operand capture on an accepted start, then one left shift of rgstr2 per RUN cycle so
    // that rgstr2 equals |multiplicand| << k while the adder is working on bit k.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgstr1 <= '0;
            r_rgstr2 <= '0;
            r_sign   <= 1'b0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_rgstr1 <= w_mplier_mag;
            r_rgstr2 <= {{(DW_2 - DW){1'b0}}, w_mcand_mag};
            r_sign   <= w_mplier_neg ^ w_mcand_neg;
            r_count  <= '0;
        end else if (r_state == StRun) begin
            r_rgstr2 <= r_rgstr2 << 1;
            r_count  <= r_count + CW'(1);
        end
    end

    // The adder must already report done in the first HOLD cycle; a miss is latched until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first_hold <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_first_hold <= w_last_run;
            if ((r_state == StHold) && r_first_hold && !done_i) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    assign rgstr1   = r_rgstr1;
    assign rgstr2   = r_rgstr2;
    assign sign     = r_sign;
    assign sync_err = r_sync_err;

endmodule
